// File: rtl/pia_uart.sv
// Apple-1 PIA keyboard/display registers (0xD010-0xD013) bridged to an 8N1 serial link.
// Received bytes appear as keypresses, display writes are transmitted, CTS holds off the host.
//
// state  | meaning (shared encoding for Rx and Tx FSMs)
// IDLE   | line idle, waiting for a start bit (Rx) or a DSP write (Tx)
// START  | start bit: Rx checks the half-bit sample, Tx drives 0
// DATA   | eight data bits, LSB first
// STOP   | stop bit: Rx samples and accepts the byte, Tx drives 1
module pia_uart #(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk25,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       uart_cts,
   input  logic       enable,
   input  logic [1:0] address,
   input  logic       w_en,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   logic          rx_s1_q, rx_s2_q;
   state_e        rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_ready_q, rx_ready_d;
   logic [6:0]    rx_char_q, rx_char_d;
   logic [6:0]    rx_conv;

   state_e        tx_st_q, tx_st_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_busy_q, tx_busy_d;
   logic          uart_tx_q, uart_tx_d;
   logic          uart_cts_q;

   logic          kbd_rd, dsp_wr;

   assign kbd_rd = enable && !w_en && (address == 2'd0);
   assign dsp_wr = enable && w_en && (address == 2'd2);

   // lower-case letters are folded to upper case before reaching the CPU
   assign rx_conv = (rx_shift_q >= 8'h61 && rx_shift_q <= 8'h7A) ?
                    (rx_shift_q[6:0] & 7'h5F) : rx_shift_q[6:0];

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_char_d  = rx_char_q;
      rx_ready_d = kbd_rd ? 1'b0 : rx_ready_q;
      case (rx_st_q)
         S_IDLE: begin
            if (!rx_s2_q) begin
               rx_st_d  = S_START;
               rx_cnt_d = HALF;
            end
         end
         S_START: begin
            if (rx_cnt_q == '0) begin
               if (rx_s2_q) begin
                  rx_st_d = S_IDLE;
               end else begin
                  rx_st_d  = S_DATA;
                  rx_cnt_d = FULL;
                  rx_idx_d = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_cnt_d   = FULL;
               if (rx_idx_q == 3'd7) rx_st_d = S_STOP;
               else                  rx_idx_d = rx_idx_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         default: begin
            if (rx_cnt_q == '0) begin
               rx_st_d = S_IDLE;
               // overrun test uses the post-read value so a same-cycle read still accepts
               if (rx_s2_q && rx_shift_q != 8'h0A && !rx_ready_d) begin
                  rx_char_d  = rx_conv;
                  rx_ready_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_comb begin
      tx_st_d    = tx_st_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_busy_d  = tx_busy_q;
      uart_tx_d  = uart_tx_q;
      case (tx_st_q)
         S_IDLE: begin
            uart_tx_d = 1'b1;
            if (dsp_wr && !tx_busy_q) begin
               tx_shift_d = din & 8'h7F;
               tx_busy_d  = 1'b1;
               tx_st_d    = S_START;
               tx_cnt_d   = FULL;
               uart_tx_d  = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt_q == '0) begin
               tx_st_d    = S_DATA;
               tx_cnt_d   = FULL;
               tx_idx_d   = 3'd0;
               uart_tx_d  = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end else begin
               tx_cnt_d = tx_cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = FULL;
               if (tx_idx_q == 3'd7) begin
                  tx_st_d   = S_STOP;
                  uart_tx_d = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  uart_tx_d  = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CW'(1);
            end
         end
         default: begin
            if (tx_cnt_q == '0) begin
               tx_st_d   = S_IDLE;
               tx_busy_d = 1'b0;
            end else begin
               tx_cnt_d = tx_cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_st_q    <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_ready_q <= 1'b0;
         rx_char_q  <= 7'h00;
         tx_st_q    <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         tx_busy_q  <= 1'b0;
         uart_tx_q  <= 1'b1;
         uart_cts_q <= 1'b1;
      end else begin
         rx_s1_q    <= uart_rx;
         rx_s2_q    <= rx_s1_q;
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_ready_q <= rx_ready_d;
         rx_char_q  <= rx_char_d;
         tx_st_q    <= tx_st_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_busy_q  <= tx_busy_d;
         uart_tx_q  <= uart_tx_d;
         uart_cts_q <= rx_ready_q;
      end
   end

   always_comb begin
      case (address)
         2'd0:    dout = {1'b1, rx_char_q};
         2'd1:    dout = {rx_ready_q, 7'b0};
         2'd2:    dout = {tx_busy_q, 7'b0};
         default: dout = 8'h00;
      endcase
   end

   assign uart_tx  = uart_tx_q;
   assign uart_cts = uart_cts_q;

endmodule

// File: tb/tb_pia_uart.sv
// Directed bench for pia_uart at DIV = 16: register map, serial Rx/Tx framing,
// filtering, overrun and mid-frame reset.
module tb_pia_uart;

   logic       clk25 = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic       uart_tx, uart_cts;
   logic       enable = 1'b0;
   logic [1:0] address = 2'd0;
   logic       w_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;

   int checks = 0;
   int errors = 0;

   pia_uart #(.CLK_FREQ(16), .BAUD(1)) dut (
      .clk25(clk25), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .uart_cts(uart_cts), .enable(enable), .address(address), .w_en(w_en),
      .din(din), .dout(dout)
   );

   always #5 clk25 = ~clk25;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_rdy;
      logic [7:0] exp_kbd;
   } rx_vec_t;

   rx_vec_t vecs[6];

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   task automatic chk_rd(input string nm, input logic [1:0] a, input logic [7:0] exp);
      address = a;
      #1;
      check(nm, dout, exp);
   endtask

   task automatic kbd_read();
      address = 2'd0;
      w_en    = 1'b0;
      enable  = 1'b1;
      tick();
      enable  = 1'b0;
   endtask

   task automatic dsp_write(input logic [7:0] v);
      address = 2'd2;
      w_en    = 1'b1;
      din     = v;
      enable  = 1'b1;
      tick();
      enable  = 1'b0;
      w_en    = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (16) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (16) tick();
      end
      uart_rx = stop;
      repeat (16) tick();
      uart_rx = 1'b1;
      repeat (16) tick();
   endtask

   logic [9:0] tx_exp;
   logic       low_seen;

   initial begin
      vecs[0] = '{8'h44, 1'b0, 8'h00, 8'hC1};
      vecs[1] = '{8'h0A, 1'b1, 8'h00, 8'hC1};
      vecs[2] = '{8'h0D, 1'b1, 8'h80, 8'h8D};
      vecs[3] = '{8'h7A, 1'b1, 8'h80, 8'hDA};
      vecs[4] = '{8'h7B, 1'b1, 8'h80, 8'hFB};
      vecs[5] = '{8'h60, 1'b1, 8'h80, 8'hE0};

      // reset
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_tx", {7'b0, uart_tx}, 8'h01);
      check("rst_cts", {7'b0, uart_cts}, 8'h01);
      rst_n = 1'b1;
      tick();
      check("cts_after_rst", {7'b0, uart_cts}, 8'h00);
      chk_rd("rst_kbd", 2'd0, 8'h80);
      chk_rd("rst_kbdcr", 2'd1, 8'h00);
      chk_rd("rst_dsp", 2'd2, 8'h00);
      chk_rd("rst_dspcr", 2'd3, 8'h00);

      // receive 'a' and clear it
      send(8'h61, 1'b1);
      chk_rd("rx61_rdy", 2'd1, 8'h80);
      chk_rd("rx61_kbd", 2'd0, 8'hC1);
      check("rx61_cts", {7'b0, uart_cts}, 8'h01);
      kbd_read();
      chk_rd("rd_clears_rdy", 2'd1, 8'h00);
      check("cts_lag", {7'b0, uart_cts}, 8'h01);
      tick();
      check("cts_drop", {7'b0, uart_cts}, 8'h00);

      // transmit 0xDC -> byte 0x5C framed as start,0,0,1,1,1,0,1,0,stop
      tx_exp   = 10'b1010111000;
      low_seen = 1'b0;
      dsp_write(8'hDC);
      chk_rd("tx_busy_set", 2'd2, 8'h80);
      for (int k = 1; k <= 200; k++) begin
         if (k == 50) begin
            address = 2'd2;
            w_en    = 1'b1;
            din     = 8'hC1;
            enable  = 1'b1;
         end
         tick();
         enable = 1'b0;
         w_en   = 1'b0;
         if (k % 16 == 8 && k < 160)
            check($sformatf("tx_bit%0d", k / 16), {7'b0, uart_tx}, {7'b0, tx_exp[k / 16]});
         if (k == 159) chk_rd("tx_busy_159", 2'd2, 8'h80);
         if (k == 160) chk_rd("tx_busy_160", 2'd2, 8'h00);
         if (k > 160 && uart_tx !== 1'b1) low_seen = 1'b1;
      end
      check("tx_no_extra_frame", {7'b0, low_seen}, 8'h00);

      // filter / conversion table
      for (int i = 0; i < 6; i++) begin
         kbd_read();
         send(vecs[i].data, vecs[i].stop);
         chk_rd($sformatf("vec%0d_rdy", i), 2'd1, vecs[i].exp_rdy);
         chk_rd($sformatf("vec%0d_kbd", i), 2'd0, vecs[i].exp_kbd);
      end

      // short glitch is rejected
      kbd_read();
      uart_rx = 1'b0;
      repeat (4) tick();
      uart_rx = 1'b1;
      repeat (40) tick();
      chk_rd("glitch_rdy", 2'd1, 8'h00);

      // overrun
      send(8'h41, 1'b1);
      send(8'h42, 1'b1);
      chk_rd("overrun_kbd", 2'd0, 8'hC1);
      kbd_read();
      chk_rd("overrun_clr", 2'd1, 8'h00);
      send(8'h43, 1'b1);
      chk_rd("after_overrun_kbd", 2'd0, 8'hC3);
      chk_rd("after_overrun_rdy", 2'd1, 8'h80);

      // reset with both Rx and Tx in DATA
      uart_rx = 1'b0;
      dsp_write(8'h00);
      repeat (40) tick();
      check("pre_rst_tx_low", {7'b0, uart_tx}, 8'h00);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_tx", {7'b0, uart_tx}, 8'h01);
      chk_rd("midrst_busy", 2'd2, 8'h00);
      chk_rd("midrst_rdy", 2'd1, 8'h00);
      uart_rx = 1'b1;
      repeat (40) tick();
      send(8'h5A, 1'b1);
      chk_rd("post_rst_kbd", 2'd0, 8'hDA);
      chk_rd("post_rst_rdy", 2'd1, 8'h80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
